// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-side program-counter sequencer for the single-cycle CPU.
// Registers the CPU's next address and feeds it back as the fetch address. It
// also provides run/pause/step/halt control, end-of-program and misalignment
// detection, and a saturating retired-instruction counter.
// Optional feature macro: PC_SEQ_BREAKPOINT_EN enables the breakpoint compare.
// When the macro is undefined, bp_valid/bp_addr are ignored and bp_hit stays 0.
module pc_sequencer #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] END_PC   = 32'h0000_0100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              step,
  input  logic              stop,
  input  logic [ADDR_W-1:0] next_addr,
  input  logic              bp_valid,
  input  logic [ADDR_W-1:0] bp_addr,
  output logic [ADDR_W-1:0] pc,
  output logic              cpu_en,
  output logic [1:0]        state,
  output logic [31:0]       retired,
  output logic              misaligned,
  output logic              bp_hit
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       retired_q, retired_d;
  logic              misaligned_q, misaligned_d;
  logic              bp_hit_q, bp_hit_d;
  logic              commit_s;
  logic              bp_match_s;

  // The counter holds at all-ones instead of wrapping back to zero.
  function automatic logic [31:0] sat_inc(input logic [31:0] val);
    if (val == 32'hFFFF_FFFF) begin
      sat_inc = val;
    end else begin
      sat_inc = val + 32'd1;
    end
  endfunction

`ifdef PC_SEQ_BREAKPOINT_EN
  assign bp_match_s = bp_valid && (next_addr == bp_addr);
`else
  logic unused_bp_s;
  assign unused_bp_s = bp_valid ^ (^bp_addr);
  assign bp_match_s  = 1'b0;
`endif

  // A commit happens in RUN unless stop is asserted. It also happens in PAUSE
  // on a bare step; start and stop both override step.
  always_comb begin
    commit_s = 1'b0;
    case (state_q)
      ST_RUN:   commit_s = ~stop;
      ST_PAUSE: commit_s = step & ~stop & ~start;
      default:  commit_s = 1'b0;
    endcase
  end

  // Next-state logic. Control transitions come first; commit checks follow in
  // priority order: misaligned, then end-of-program, then breakpoint.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    retired_d    = retired_q;
    misaligned_d = misaligned_q;
    bp_hit_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_PAUSE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (stop) begin
          state_d = ST_PAUSE;
        end else if (start) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_PAUSE;
        end
      end
      ST_HALT: begin
        if (start && !stop) begin
          state_d      = ST_RUN;
          pc_d         = RESET_PC;
          retired_d    = 32'd0;
          misaligned_d = 1'b0;
        end else begin
          state_d = ST_HALT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (commit_s) begin
      if (next_addr[1:0] != 2'b00) begin
        misaligned_d = 1'b1;
        state_d      = ST_HALT;
      end else if (next_addr == END_PC) begin
        pc_d      = END_PC;
        retired_d = sat_inc(retired_q);
        state_d   = ST_HALT;
      end else if (bp_match_s) begin
        pc_d      = next_addr;
        retired_d = sat_inc(retired_q);
        bp_hit_d  = 1'b1;
        state_d   = ST_PAUSE;
      end else begin
        pc_d      = next_addr;
        retired_d = sat_inc(retired_q);
      end
    end else begin
      bp_hit_d = 1'b0;
    end
  end

  // State registers. Reset is asynchronous, so the outputs drop at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      retired_q    <= 32'd0;
      misaligned_q <= 1'b0;
      bp_hit_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      retired_q    <= retired_d;
      misaligned_q <= misaligned_d;
      bp_hit_q     <= bp_hit_d;
    end
  end

  assign pc         = pc_q;
  assign state      = state_q;
  assign retired    = retired_q;
  assign misaligned = misaligned_q;
  assign bp_hit     = bp_hit_q;
  assign cpu_en     = commit_s;

endmodule
